// File: rtl/ex_operand_stage_pkg.sv
// Shared widths, ALU operation codes and the holding-register layout for the
// operand stage that sits directly in front of the ALU.
package ex_operand_stage_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Everything the stage remembers about one decoded instruction.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [RA_W-1:0] rs1_addr;
        logic [RA_W-1:0] rs2_addr;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            src1_pc;
        logic            src2_imm;
        logic [3:0]      alu_control;
        logic [RA_W-1:0] rd_addr;
        logic            reg_write;
    } held_t;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Picks the freshest value of one source register: EX/MEM beats MEM/WB beats
// the supplied base value, and x0 always reads as zero.
module operand_fwd_mux
    import ex_operand_stage_pkg::*;
(
    input  logic [RA_W-1:0] idx,
    input  logic [XLEN-1:0] base,
    input  logic            fx_valid,
    input  logic [RA_W-1:0] fx_rd,
    input  logic [XLEN-1:0] fx_data,
    input  logic            fw_valid,
    input  logic [RA_W-1:0] fw_rd,
    input  logic [XLEN-1:0] fw_data,
    output logic [XLEN-1:0] value,
    output logic            match
);

    // NOTE: every output gets a default before the priority chain, so no
    // path through this block can leave a latch behind.
    always_comb begin
        value = base;
        match = 1'b0;
        if (idx == '0) begin
            value = '0;
        end else if (fx_valid && (fx_rd == idx)) begin
            value = fx_data;
            match = 1'b1;
        end else if (fw_valid && (fw_rd == idx)) begin
            value = fw_data;
            match = 1'b1;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// Single-entry valid/ready pipeline register in front of the ALU, with
// operand forwarding at capture, sticky refresh while stalled and a live overlay.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RA_W-1:0] in_rs1_addr,
    input  logic [RA_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_src1_pc,
    input  logic            in_src2_imm,
    input  logic [3:0]      in_alu_control,
    input  logic [RA_W-1:0] in_rd_addr,
    input  logic            in_reg_write,
    input  logic            flush,
    input  logic            fx_valid,
    input  logic [RA_W-1:0] fx_rd,
    input  logic [XLEN-1:0] fx_data,
    input  logic            fw_valid,
    input  logic [RA_W-1:0] fw_rd,
    input  logic [XLEN-1:0] fw_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] data1,
    output logic [XLEN-1:0] data2,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] out_rs2,
    output logic [XLEN-1:0] out_pc,
    output logic [RA_W-1:0] out_rd_addr,
    output logic            out_reg_write
);

    held_t           held;
    held_t           cap_entry;
    logic            held_valid;
    logic            capture;
    logic [XLEN-1:0] rs1_cap;
    logic [XLEN-1:0] rs2_cap;
    logic [XLEN-1:0] rs1_live;
    logic [XLEN-1:0] rs2_live;
    logic            rs1_cap_match;
    logic            rs2_cap_match;
    logic            rs1_live_match;
    logic            rs2_live_match;
    logic            unused_cap_match;

    // Depends only on the output side, so no combinational path from in_valid.
    assign in_ready = !held_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Capture-side forwarding on the incoming register-file reads.
    operand_fwd_mux u_rs1_cap (
        .idx      (in_rs1_addr),
        .base     (in_rs1_data),
        .fx_valid (fx_valid),
        .fx_rd    (fx_rd),
        .fx_data  (fx_data),
        .fw_valid (fw_valid),
        .fw_rd    (fw_rd),
        .fw_data  (fw_data),
        .value    (rs1_cap),
        .match    (rs1_cap_match)
    );

    operand_fwd_mux u_rs2_cap (
        .idx      (in_rs2_addr),
        .base     (in_rs2_data),
        .fx_valid (fx_valid),
        .fx_rd    (fx_rd),
        .fx_data  (fx_data),
        .fw_valid (fw_valid),
        .fw_rd    (fw_rd),
        .fw_data  (fw_data),
        .value    (rs2_cap),
        .match    (rs2_cap_match)
    );

    // Held-side muxes serve both the output overlay and the sticky refresh.
    operand_fwd_mux u_rs1_live (
        .idx      (held.rs1_addr),
        .base     (held.rs1_data),
        .fx_valid (fx_valid),
        .fx_rd    (fx_rd),
        .fx_data  (fx_data),
        .fw_valid (fw_valid),
        .fw_rd    (fw_rd),
        .fw_data  (fw_data),
        .value    (rs1_live),
        .match    (rs1_live_match)
    );

    operand_fwd_mux u_rs2_live (
        .idx      (held.rs2_addr),
        .base     (held.rs2_data),
        .fx_valid (fx_valid),
        .fx_rd    (fx_rd),
        .fx_data  (fx_data),
        .fw_valid (fw_valid),
        .fw_rd    (fw_rd),
        .fw_data  (fw_data),
        .value    (rs2_live),
        .match    (rs2_live_match)
    );

    // The capture muxes already fold the match into their value.
    assign unused_cap_match = rs1_cap_match | rs2_cap_match;

    always_comb begin
        cap_entry             = '0;
        cap_entry.pc          = in_pc;
        cap_entry.rs1_addr    = in_rs1_addr;
        cap_entry.rs2_addr    = in_rs2_addr;
        cap_entry.rs1_data    = rs1_cap;
        cap_entry.rs2_data    = rs2_cap;
        cap_entry.imm         = in_imm;
        cap_entry.src1_pc     = in_src1_pc;
        cap_entry.src2_imm    = in_src2_imm;
        cap_entry.alu_control = in_alu_control;
        cap_entry.rd_addr     = in_rd_addr;
        cap_entry.reg_write   = in_reg_write;
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // branch below sees the pre-edge value of held/held_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the whole holding register is reset, not just the valid
            // bit, because the operand outputs must read zero out of reset.
            held_valid <= 1'b0;
            held       <= '0;
        end else if (flush) begin
            held_valid <= 1'b0;
        end else if (capture) begin
            held_valid <= 1'b1;
            held       <= cap_entry;
        end else if (held_valid && !out_ready) begin
            if (rs1_live_match) held.rs1_data <= rs1_live;
            if (rs2_live_match) held.rs2_data <= rs2_live;
        end else begin
            held_valid <= 1'b0;
        end
    end

    assign out_valid     = held_valid;
    assign data1         = held.src1_pc  ? held.pc  : rs1_live;
    assign data2         = held.src2_imm ? held.imm : rs2_live;
    assign out_rs2       = rs2_live;
    assign alu_control   = held.alu_control;
    assign out_pc        = held.pc;
    assign out_rd_addr   = held.rd_addr;
    assign out_reg_write = held_valid && held.reg_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [RA_W-1:0] in_rs1_addr;
    logic [RA_W-1:0] in_rs2_addr;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic            in_src1_pc;
    logic            in_src2_imm;
    logic [3:0]      in_alu_control;
    logic [RA_W-1:0] in_rd_addr;
    logic            in_reg_write;
    logic            flush;
    logic            fx_valid;
    logic [RA_W-1:0] fx_rd;
    logic [XLEN-1:0] fx_data;
    logic            fw_valid;
    logic [RA_W-1:0] fw_rd;
    logic [XLEN-1:0] fw_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] out_rs2;
    logic [XLEN-1:0] out_pc;
    logic [RA_W-1:0] out_rd_addr;
    logic            out_reg_write;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_rs1_addr    (in_rs1_addr),
        .in_rs2_addr    (in_rs2_addr),
        .in_rs1_data    (in_rs1_data),
        .in_rs2_data    (in_rs2_data),
        .in_imm         (in_imm),
        .in_src1_pc     (in_src1_pc),
        .in_src2_imm    (in_src2_imm),
        .in_alu_control (in_alu_control),
        .in_rd_addr     (in_rd_addr),
        .in_reg_write   (in_reg_write),
        .flush          (flush),
        .fx_valid       (fx_valid),
        .fx_rd          (fx_rd),
        .fx_data        (fx_data),
        .fw_valid       (fw_valid),
        .fw_rd          (fw_rd),
        .fw_data        (fw_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data1          (data1),
        .data2          (data2),
        .alu_control    (alu_control),
        .out_rs2        (out_rs2),
        .out_pc         (out_pc),
        .out_rd_addr    (out_rd_addr),
        .out_reg_write  (out_reg_write)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rd;
        logic        s1pc;
        logic        s2imm;
        logic        rw;
        logic [3:0]  alu;
    } model_t;

    model_t m;

    // Newest value of register idx as seen right now; base is the older copy.
    function automatic logic [31:0] newest(input logic [4:0] idx, input logic [31:0] base);
        if (idx == 5'd0) return 32'd0;
        if (fx_valid && fx_rd == idx) return fx_data;
        if (fw_valid && fw_rd == idx) return fw_data;
        return base;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '0;
        end else if (flush) begin
            m.valid <= 1'b0;
        end else if (in_valid && (!m.valid || out_ready)) begin
            m.valid <= 1'b1;
            m.pc    <= in_pc;
            m.rs1a  <= in_rs1_addr;
            m.rs2a  <= in_rs2_addr;
            m.rs1   <= newest(in_rs1_addr, in_rs1_data);
            m.rs2   <= newest(in_rs2_addr, in_rs2_data);
            m.imm   <= in_imm;
            m.s1pc  <= in_src1_pc;
            m.s2imm <= in_src2_imm;
            m.alu   <= in_alu_control;
            m.rd    <= in_rd_addr;
            m.rw    <= in_reg_write;
        end else if (m.valid && !out_ready) begin
            m.rs1 <= newest(m.rs1a, m.rs1);
            m.rs2 <= newest(m.rs2a, m.rs2);
        end else begin
            m.valid <= 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] r1;
        logic [31:0] r2;
        if (cmp_en) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m.valid});
            check("in_ready", {31'd0, in_ready}, {31'd0, !m.valid || out_ready});
            check("out_reg_write", {31'd0, out_reg_write}, {31'd0, m.valid && m.rw});
            if (m.valid) begin
                r1 = newest(m.rs1a, m.rs1);
                r2 = newest(m.rs2a, m.rs2);
                check("data1", data1, m.s1pc ? m.pc : r1);
                check("data2", data2, m.s2imm ? m.imm : r2);
                check("out_rs2", out_rs2, r2);
                check("alu_control", {28'd0, alu_control}, {28'd0, m.alu});
                check("out_pc", out_pc, m.pc);
                check("out_rd_addr", {27'd0, out_rd_addr}, {27'd0, m.rd});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_pc = 0; in_rs1_addr = 0; in_rs2_addr = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_src1_pc = 0;
        in_src2_imm = 0; in_alu_control = 0; in_rd_addr = 0; in_reg_write = 0;
        flush = 0; fx_valid = 0; fx_rd = 0; fx_data = 0;
        fw_valid = 0; fw_rd = 0; fw_data = 0; out_ready = 1;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] r1a, input logic [31:0] r1d,
                             input logic [4:0] r2a, input logic [31:0] r2d, input logic [31:0] imm,
                             input logic s1pc, input logic s2imm, input logic [3:0] alu,
                             input logic [4:0] rd, input logic rw);
        in_pc = pc; in_rs1_addr = r1a; in_rs1_data = r1d; in_rs2_addr = r2a;
        in_rs2_data = r2d; in_imm = imm; in_src1_pc = s1pc; in_src2_imm = s2imm;
        in_alu_control = alu; in_rd_addr = rd; in_reg_write = rw;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, " data1"}, data1, 32'd0);
        check({tag, " data2"}, data2, 32'd0);
        check({tag, " out_rs2"}, out_rs2, 32'd0);
        check({tag, " out_pc"}, out_pc, 32'd0);
        check({tag, " alu_control"}, {28'd0, alu_control}, 32'd0);
        check({tag, " out_rd_addr"}, {27'd0, out_rd_addr}, 32'd0);
        check({tag, " out_reg_write"}, {31'd0, out_reg_write}, 32'd0);
    endtask

    initial begin
        idle();
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst_n = 1;
        cmp_en = 1;
        tick();

        // Plain ADD x3 = x1 + x2
        set_instr(32'h40, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 0, 0, ALU_ADD, 5'd3, 1);
        in_valid = 1;
        tick();
        in_valid = 0;
        check("add out_valid", {31'd0, out_valid}, 32'd1);
        check("add data1", data1, 32'd5);
        check("add data2", data2, 32'd7);
        check("add alu_control", {28'd0, alu_control}, {28'd0, ALU_ADD});
        check("add out_rd_addr", {27'd0, out_rd_addr}, 32'd3);
        check("add out_reg_write", {31'd0, out_reg_write}, 32'd1);

        // fx and fw both hit rs1 at capture: fx wins and is stored
        fx_valid = 1; fx_rd = 5'd1; fx_data = 32'h100;
        fw_valid = 1; fw_rd = 5'd1; fw_data = 32'h200;
        in_valid = 1;
        tick();
        in_valid = 0;
        check("fx prio live data1", data1, 32'h100);
        fx_valid = 0; fw_valid = 0;
        #1;
        check("fx prio stored data1", data1, 32'h100);

        // x0 source ignores both regfile data and a forward to x0
        set_instr(32'h44, 5'd0, 32'hDEAD, 5'd2, 32'd7, 32'd0, 0, 0, ALU_SUB, 5'd3, 1);
        fx_valid = 1; fx_rd = 5'd0; fx_data = 32'h55;
        in_valid = 1;
        tick();
        in_valid = 0;
        check("x0 data1", data1, 32'd0);
        fx_valid = 0;

        // Three-cycle stall with a fw pulse on rs2 in the second cycle
        set_instr(32'h48, 5'd1, 32'd1, 5'd2, 32'd7, 32'd0, 0, 0, ALU_OR, 5'd4, 1);
        in_valid = 1; out_ready = 0;
        tick();
        in_valid = 0;
        check("stall1 in_ready", {31'd0, in_ready}, 32'd0);
        check("stall1 data2", data2, 32'd7);
        tick();
        fw_valid = 1; fw_rd = 5'd2; fw_data = 32'd9;
        #1;
        check("stall2 in_ready", {31'd0, in_ready}, 32'd0);
        check("stall2 data2", data2, 32'd9);
        tick();
        fw_valid = 0;
        #1;
        check("stall3 in_ready", {31'd0, in_ready}, 32'd0);
        check("stall3 sticky data2", data2, 32'd9);
        check("stall3 out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1;
        #1;
        check("release in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("release no duplicate", {31'd0, out_valid}, 32'd0);

        // AUIPC-style select with a forwarded store operand
        set_instr(32'h1000, 5'd1, 32'd3, 5'd2, 32'h33, 32'hFFFFF800, 1, 1, ALU_ADD, 5'd6, 1);
        fx_valid = 1; fx_rd = 5'd2; fx_data = 32'h44;
        in_valid = 1;
        tick();
        in_valid = 0; fx_valid = 0;
        #1;
        check("pcimm data1", data1, 32'h1000);
        check("pcimm data2", data2, 32'hFFFFF800);
        check("pcimm out_rs2", out_rs2, 32'h44);

        // Flush kills both the held and the incoming instruction
        set_instr(32'h50, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 0, 0, ALU_AND, 5'd5, 1);
        in_valid = 1; out_ready = 0;
        tick();
        check("pre-flush out_valid", {31'd0, out_valid}, 32'd1);
        set_instr(32'h54, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 0, 0, ALU_XOR, 5'd7, 1);
        out_ready = 1; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        check("flush out_valid", {31'd0, out_valid}, 32'd0);
        check("flush out_reg_write", {31'd0, out_reg_write}, 32'd0);

        // Back-to-back capture with no bubble
        set_instr(32'h60, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 0, 0, ALU_SLT, 5'd6, 1);
        in_valid = 1;
        tick();
        check("b2b first rd", {27'd0, out_rd_addr}, 32'd6);
        set_instr(32'h64, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 0, 0, ALU_SLTU, 5'd7, 1);
        tick();
        in_valid = 0;
        check("b2b second valid", {31'd0, out_valid}, 32'd1);
        check("b2b second rd", {27'd0, out_rd_addr}, 32'd7);
        tick();

        // Randomized traffic, small register space to force many matches
        for (int i = 0; i < 3000; i++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            in_pc          = $urandom;
            in_rs1_addr    = 5'($urandom_range(0, 3));
            in_rs2_addr    = 5'($urandom_range(0, 3));
            in_rs1_data    = $urandom;
            in_rs2_data    = $urandom;
            in_imm         = $urandom;
            in_src1_pc     = 1'($urandom_range(0, 1));
            in_src2_imm    = 1'($urandom_range(0, 1));
            in_alu_control = 4'($urandom_range(0, 9));
            in_rd_addr     = 5'($urandom_range(0, 31));
            in_reg_write   = 1'($urandom_range(0, 1));
            flush          = ($urandom_range(0, 15) == 0);
            fx_valid       = 1'($urandom_range(0, 1));
            fx_rd          = 5'($urandom_range(0, 3));
            fx_data        = $urandom;
            fw_valid       = 1'($urandom_range(0, 1));
            fw_rd          = 5'($urandom_range(0, 3));
            fw_data        = $urandom;
            out_ready      = ($urandom_range(0, 2) != 0);
            tick();
        end

        // Asynchronous reset in the middle of a stall
        idle();
        set_instr(32'h2000, 5'd1, 32'd11, 5'd2, 32'd22, 32'd33, 0, 0, ALU_SRA, 5'd9, 1);
        in_valid = 1; out_ready = 0;
        tick();
        in_valid = 0;
        check("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
        #1 rst_n = 0;
        #1;
        check_all_zero("async reset");
        @(posedge clk);
        #1 rst_n = 1;
        out_ready = 1;
        tick();
        check("post-reset out_valid", {31'd0, out_valid}, 32'd0);
        tick();

        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Pipeline register and operand-select stage directly upstream of the ALU. It captures one decoded instruction from the decode stage and holds it under a valid/ready handshake. It resolves data hazards by forwarding from the EX/MEM and MEM/WB results. It drives the ALU's `data1`, `data2` and `ALU_control` inputs, and passes destination and store information downstream.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  instruction PC
- in_rs1_addr, in_rs2_addr  in  RA_W  source register indices
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_src1_pc  in  1  data1 = PC instead of rs1 (AUIPC/JAL)
- in_src2_imm  in  1  data2 = imm instead of rs2
- in_alu_control  in  4  ALU operation code (0000 ADD … 1001 SLTU)
- in_rd_addr  in  RA_W  destination register
- in_reg_write  in  1  instruction writes rd
- flush  in  1  kill held and incoming instruction (branch redirect)
- fx_valid, fx_rd, fx_data  in  1/RA_W/XLEN  EX/MEM forward source
- fw_valid, fw_rd, fw_data  in  1/RA_W/XLEN  MEM/WB forward source
- out_valid  out  1  held instruction valid
- out_ready  in  1  downstream consumes this cycle
- data1, data2  out  XLEN  ALU operands
- alu_control  out  4  to ALU
- out_rs2  out  XLEN  forwarded rs2 (store data)
- out_pc, out_rd_addr, out_reg_write  out  XLEN/RA_W/1  passthrough

## Operation
- Single holding register. `in_ready = !out_valid || out_ready`.
- Capture when `in_valid && in_ready && !flush`. `out_valid` becomes 1 on the next edge.
- Hold while `out_valid && !out_ready`. All held fields stay stable except the rs1/rs2 values refreshed by forwarding (below).
- Forward match: source valid, source rd == reg index, and reg index ≠ 0. Priority is fx > fw > stored/regfile data.
- At capture, the stored rs values take the forwarded value if a match exists, else `in_rsN_data`.
- While holding, each cycle a match overwrites the stored rs value (sticky refresh). A stalled instruction therefore never loses a result that has already retired past the forward points.
- Outputs: `out_rs2` and the rs path of the operands carry a live fx/fw overlay on the stored value, so a same-cycle match is visible combinationally.
- `data1 = src1_pc ? pc : rs1_fwd`; `data2 = src2_imm ? imm : rs2_fwd`. `out_rs2` is always `rs2_fwd`.
- x0 reads always give 0, irrespective of forward ports or regfile data.
- Flush has highest priority: `out_valid` is 0 next cycle and any simultaneous capture is dropped. Other fields are don't-care.
- `out_reg_write` is gated: it is 0 whenever `out_valid` = 0.

## Timing
- Latency: capture edge to `out_valid` is 1 cycle.
- Throughput: 1 instruction/cycle when `out_ready` is held high.
- Reset (async assert, sync-safe deassert at clk): `out_valid`=0, all stored fields 0, hence `data1`/`data2`/`out_rs2`/`out_pc`=0, `alu_control`=0000, `out_rd_addr`=0, `out_reg_write`=0.
- Reset mid-stall discards the held instruction.
- Simultaneous consume and capture in one cycle: the new instruction replaces the old with no bubble.
- fx and fw matching the same register: fx wins, including for sticky refresh.
- The forward overlay is combinational from the fx*/fw* inputs to the outputs. This is the critical path: forward mux, then the ALU.
- `in_ready` is a function of `out_valid`/`out_ready` only, never of `in_valid` (no loop).

## Structure
- The shared package holds:
  - XLEN and RA_W
  - ALU op localparams: ALU_ADD=0000, ALU_SUB=0001, ALU_XOR=0010, ALU_OR=0011, ALU_AND=0100, ALU_SLL=0101, ALU_SRL=0110, ALU_SRA=0111, ALU_SLT=1000, ALU_SLTU=1001
- Sub-module `operand_fwd_mux`: inputs reg index, base value, fx/fw triplets. Outputs the forwarded value and a match flag. Instantiated twice for capture/refresh and twice for the output overlay, or shared per operand.

## Test plan
- Reset, then in_valid with rs1=x1 (data 5), rs2=x2 (data 7), ALU_ADD, rd=x3 → next cycle: out_valid=1, data1=5, data2=7, alu_control=0000, out_rd_addr=3, out_reg_write=1.
- Same instruction with fx_valid, fx_rd=1, fx_data=0x100, and fw_valid, fw_rd=1, fw_data=0x200 → data1=0x100 (fx priority).
- rs1=x0, regfile data 0xDEAD, and fx_rd=0, fx_data=0x55 → data1=0.
- Hold out_ready=0 for 3 cycles; fw_valid, fw_rd=2, fw_data=9 pulses in cycle 2 only → data2=9 from cycle 2 onward, in_ready=0 throughout. Release out_ready → one consume, no duplicate.
- in_src1_pc=1, in_src2_imm=1, pc=0x1000, imm=0xFFFFF800 → data1=0x1000, data2=0xFFFFF800, out_rs2 = forwarded rs2.
- flush asserted with in_valid and a held instruction → next cycle out_valid=0, out_reg_write=0. Async rst_n low mid-stall → all outputs 0 immediately.
